sdf_bf_stage64: RTL and testbench
=================================

// Module: sdf_bf_stage64
// PURPOSE
//  Radix-2 single-path delay-feedback (SDF) butterfly stage for a 64-point FFT section.
//  It consumes the stage state and the Q8 twiddle (w_r/w_i) from the 32-entry twiddle ROM
//  in the same clk domain. That ROM advances on the same in_valid; state/twiddle are
//  sample-aligned.
//  Output is a complex stream in SDF order, with one registered sample per valid butterfly slot.
// PARAMETERS
//  DW    24  data/twiddle width, two's complement
//  DEPTH 32  feedback delay length (N/2 for 64-point stage)
//  FRAC  8   twiddle fractional bits (1.0 = 256)
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  in_valid  in   1   din_r/din_i/state/w_r/w_i valid this cycle
//  din_r     in   DW  input sample, real
//  din_i     in   DW  input sample, imaginary
//  state     in   2   0=fill, 1=butterfly, 2=twiddle, 3=reserved
//  w_r       in   DW  twiddle real, Q(DW-FRAC).FRAC
//  w_i       in   DW  twiddle imaginary
//  out_valid out  1   dout valid
//  dout_r    out  DW  output sample, real
//  dout_i    out  DW  output sample, imaginary
// BEHAVIOUR
//  - Reset: out_valid=0, dout_r=dout_i=0, buffer pointer=0.
//    Buffer RAM contents are not reset (don't care; state 0 refills it).
//  - Delay buffer: DEPTH x 2*DW circular buffer with wrap pointer 0..DEPTH-1.
//    Each in_valid cycle with state 0/1/2 reads entry[ptr] as d, writes entry[ptr], then ptr+1 mod DEPTH.
//  - in_valid=0: no read/write, ptr holds, out_valid=0 next cycle, dout holds last value.
//  - state 0 (fill): write din; no output.
//  - state 1 (butterfly): a=d, b=din.
//    Output a+b; write a-b into buffer.
//  - state 2 (twiddle): output d*W as a complex multiply; write din (next frame's first half).
//  - state 3: treated as in_valid=0 (no write, ptr holds, no output).
//  - Latency: 1 cycle. out_valid registered high the cycle after a valid state-1/2 input.
//  - Add/sub: DW-bit wrap-around, no saturation, no growth bit.
//  - Multiply: p_r=d_r*w_r-d_i*w_i and p_i=d_r*w_i+d_i*w_r, each at 2*DW bits.
//    Arithmetic shift right by FRAC (truncate toward -inf), then keep low DW bits.
//  - Continuous frames: state sequence 0,(1,2)* with 32 samples each.
//    The final frame is flushed by upstream supplying 32 dummy valid samples in state 2.
//  - Reset mid-frame: immediate clear per reset list; next frame restarts from state 0.
// STRUCTURE
//  - Shared package/header fft_defs: FFT_DW=24, FFT_FRAC=8, and state encodings.
//    The encodings are ST_FILL=0, ST_BF=1, ST_TW=2.
//  - One sub-module, fft_cmul: combinational DW x DW complex multiply with FRAC shift.
//    It is reused by later stages.
//  - Buffer is inferred RAM or register array; the stage top holds ptr, butterfly and output regs.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> out_valid=0, dout=0 next edge; ptr restarts at 0.
//  2 Butterfly with W=(256,0): feed 32x state0 din_r=n, then 32x state1 din_r=100.
//    Expect out n+100 (n=0..31); next 32x state2 expect dout_r=n-100, dout_i=0.
//  3 Twiddle -j: buffered (10,0), W=(0,-256) -> dout=(0,-10).
//    Buffered (256,0), W=(181,-181) -> dout=(181,-181).
//  4 Gaps: drop in_valid for 5 cycles at sample 10 of state 1.
//    Expect no out_valid in the gap, then an output sequence identical to test 2.
//  5 Wrap: a=b=24'h7FFFFF in state 1 -> dout_r=24'hFFFFFE; buffered a-b=0.
//    Also in state 2, (-1,0)*(1,0) -> dout_r=24'hFFFFFF (floor).
//  6 Reserved state 3 for 4 cycles mid-frame -> no output, no buffer write, ptr unchanged.

Source files
------------

// File: rtl/fft_defs.sv
// Shared FFT definitions: default datapath widths and the per-sample stage-state encoding.
package fft_defs;

  localparam int unsigned FFT_DW   = 24;
  localparam int unsigned FFT_FRAC = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_RSV  = 2'd3
  } fft_state_e;

endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply of a by a Q-format twiddle b; the full-width result is
// floor-shifted by FRAC and wrapped to DW bits.
module fft_cmul #(
  parameter int unsigned DW   = 24,
  parameter int unsigned FRAC = 8
) (
  input  logic [DW-1:0] a_r,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_r,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] p_r,
  output logic [DW-1:0] p_i
);

  logic signed [2*DW-1:0] ar, ai, br, bi;
  logic signed [2*DW-1:0] full_r, full_i;

  always_comb begin
    ar     = {{DW{a_r[DW-1]}}, a_r};
    ai     = {{DW{a_i[DW-1]}}, a_i};
    br     = {{DW{b_r[DW-1]}}, b_r};
    bi     = {{DW{b_i[DW-1]}}, b_i};
    full_r = ar * br - ai * bi;
    full_i = ar * bi + ai * br;
    // Arithmetic shift rounds toward -inf; the cast keeps the low DW bits.
    p_r    = DW'(full_r >>> FRAC);
    p_i    = DW'(full_i >>> FRAC);
  end

endmodule

// File: rtl/sdf_bf_stage64.sv
// Radix-2 SDF butterfly stage: circular feedback buffer, butterfly add/sub, twiddle multiply,
// and a one-cycle registered output.
module sdf_bf_stage64
  import fft_defs::*;
#(
  parameter int unsigned DW    = FFT_DW,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned FRAC  = FFT_FRAC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  fft_state_e      st;
  logic            act;
  logic [DW-1:0]   d_r, d_i, sum_r, sum_i, diff_r, diff_i, mul_r, mul_i;
  logic [2*DW-1:0] wdata;

  fft_cmul #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_cmul (
    .a_r (d_r),
    .a_i (d_i),
    .b_r (w_r),
    .b_i (w_i),
    .p_r (mul_r),
    .p_i (mul_i)
  );

  always_comb begin
    st         = fft_state_e'(state);
    // Reserved state behaves exactly like an idle cycle.
    act        = in_valid && (st != ST_RSV);
    {d_r, d_i} = mem[ptr_q];
    sum_r      = d_r + din_r;
    sum_i      = d_i + din_i;
    diff_r     = d_r - din_r;
    diff_i     = d_i - din_i;
    wdata      = (st == ST_BF) ? {diff_r, diff_i} : {din_r, din_i};
    ptr_d      = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Buffer contents are never reset; a fill pass overwrites them.
  always_ff @(posedge clk) begin
    if (act) begin
      mem[ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else if (act) begin
      ptr_q     <= ptr_d;
      out_valid <= (st == ST_BF) || (st == ST_TW);
      if (st == ST_BF) begin
        dout_r <= sum_r;
        dout_i <= sum_i;
      end else if (st == ST_TW) begin
        dout_r <= mul_r;
        dout_i <= mul_i;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage64.sv
// Self-checking bench for sdf_bf_stage64: directed frames, a vector table, and random frames
// against a sample-level reference model.
module tb_sdf_bf_stage64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] din_r, din_i, w_r, w_i;
  logic [1:0]  state;
  logic        out_valid;
  logic [23:0] dout_r, dout_i;

  always #5 clk = ~clk;

  sdf_bf_stage64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: 32-sample complex delay line plus the held output.
  logic [23:0] mbr [32];
  logic [23:0] mbi [32];
  int          mptr;
  logic        exp_v;
  logic [23:0] exp_r, exp_i;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [23:0] cmul_ref(input logic [23:0] ar, input logic [23:0] ai,
                                           input logic [23:0] br, input logic [23:0] bi,
                                           input bit imag);
    longint sar, sai, sbr, sbi, p;
    sar = longint'($signed(ar));
    sai = longint'($signed(ai));
    sbr = longint'($signed(br));
    sbi = longint'($signed(bi));
    p   = imag ? (sar * sbi + sai * sbr) : (sar * sbr - sai * sbi);
    p   = p >>> 8;
    return p[23:0];
  endfunction

  task automatic step(input logic v, input logic [1:0] st, input logic [23:0] dr,
                      input logic [23:0] di, input logic [23:0] wr, input logic [23:0] wi);
    logic [23:0] ar, ai;
    in_valid = v;
    state    = st;
    din_r    = dr;
    din_i    = di;
    w_r      = wr;
    w_i      = wi;
    @(posedge clk);
    if (v && st != 2'd3) begin
      ar = mbr[mptr];
      ai = mbi[mptr];
      case (st)
        2'd0: begin
          mbr[mptr] = dr;
          mbi[mptr] = di;
          exp_v     = 1'b0;
        end
        2'd1: begin
          exp_r     = ar + dr;
          exp_i     = ai + di;
          mbr[mptr] = ar - dr;
          mbi[mptr] = ai - di;
          exp_v     = 1'b1;
        end
        default: begin
          exp_r     = cmul_ref(ar, ai, wr, wi, 1'b0);
          exp_i     = cmul_ref(ar, ai, wr, wi, 1'b1);
          mbr[mptr] = dr;
          mbi[mptr] = di;
          exp_v     = 1'b1;
        end
      endcase
      mptr = (mptr + 1) % 32;
    end else begin
      exp_v = 1'b0;
    end
    #1;
    chk("out_valid", {23'd0, out_valid}, {23'd0, exp_v});
    chk("dout_r", dout_r, exp_r);
    chk("dout_i", dout_i, exp_i);
  endtask

  task automatic model_reset();
    mptr  = 0;
    exp_v = 1'b0;
    exp_r = '0;
    exp_i = '0;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  st;
    logic [23:0] dr, di, wr, wi;
    logic        ev;
    logic [23:0] er, ei;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Buffer after the directed fill: 0:(10,0) 1:(256,0) 2:(-1,0) 3:(max,0), rest zero.
    tbl[0] = '{1'b1, 2'd2, 24'd0, 24'd0, 24'd0, 24'hFFFF00, 1'b1, 24'd0, 24'hFFFFF6};
    tbl[1] = '{1'b1, 2'd2, 24'd0, 24'd0, 24'd181, 24'hFFFF4B, 1'b1, 24'd181, 24'hFFFF4B};
    tbl[2] = '{1'b1, 2'd2, 24'd0, 24'd0, 24'd1, 24'd0, 1'b1, 24'hFFFFFF, 24'd0};
    tbl[3] = '{1'b0, 2'd1, 24'd9, 24'd9, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0};
    tbl[4] = '{1'b1, 2'd3, 24'd9, 24'd9, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0};
    tbl[5] = '{1'b1, 2'd1, 24'h7FFFFF, 24'd0, 24'd0, 24'd0, 1'b1, 24'hFFFFFE, 24'd0};
    tbl[6] = '{1'b1, 2'd1, 24'd5, 24'd3, 24'd0, 24'd0, 1'b1, 24'd5, 24'd3};
    tbl[7] = '{1'b0, 2'd2, 24'd0, 24'd0, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0};

    rst_n = 1'b0; in_valid = 1'b0; state = 2'd0;
    din_r = '0; din_i = '0; w_r = '0; w_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {23'd0, out_valid}, 24'd0);
    chk("rst_dout_r", dout_r, 24'd0);
    chk("rst_dout_i", dout_i, 24'd0);
    rst_n = 1'b1;

    // Butterfly/twiddle frame with unit twiddle.
    for (int n = 0; n < 32; n++) step(1'b1, 2'd0, 24'(n), 24'd0, 24'd0, 24'd0);
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 2'd1, 24'd100, 24'd0, 24'd0, 24'd0);
      chk("t2_sum_r", dout_r, 24'(n + 100));
    end
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 2'd2, 24'd0, 24'd0, 24'd256, 24'd0);
      chk("t2_tw_r", dout_r, 24'(n - 100));
      chk("t2_tw_i", dout_i, 24'd0);
    end

    // Reset in the middle of a butterfly pass.
    for (int n = 0; n < 32; n++) step(1'b1, 2'd0, 24'(n + 7), 24'd1, 24'd0, 24'd0);
    for (int n = 0; n < 10; n++) step(1'b1, 2'd1, 24'd3, 24'd2, 24'd0, 24'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {23'd0, out_valid}, 24'd0);
    chk("midrst_dout_r", dout_r, 24'd0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_edge_valid", {23'd0, out_valid}, 24'd0);
    chk("midrst_edge_dout_i", dout_i, 24'd0);
    rst_n = 1'b1;

    // Same frame as before with a 5-cycle gap at butterfly sample 10.
    for (int n = 0; n < 32; n++) step(1'b1, 2'd0, 24'(n), 24'd0, 24'd0, 24'd0);
    for (int n = 0; n < 32; n++) begin
      if (n == 10) begin
        for (int g = 0; g < 5; g++) begin
          step(1'b0, 2'd1, 24'd55, 24'd55, 24'd0, 24'd0);
          chk("gap_no_valid", {23'd0, out_valid}, 24'd0);
        end
      end
      step(1'b1, 2'd1, 24'd100, 24'd0, 24'd0, 24'd0);
      chk("gap_sum_r", dout_r, 24'(n + 100));
    end
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 2'd2, 24'd0, 24'd0, 24'd256, 24'd0);
      chk("gap_tw_r", dout_r, 24'(n - 100));
    end

    // Vector table: twiddles, floor rounding, wrap, idle and reserved cycles.
    for (int n = 0; n < 32; n++) begin
      case (n)
        0: step(1'b1, 2'd0, 24'd10, 24'd0, 24'd0, 24'd0);
        1: step(1'b1, 2'd0, 24'd256, 24'd0, 24'd0, 24'd0);
        2: step(1'b1, 2'd0, 24'hFFFFFF, 24'd0, 24'd0, 24'd0);
        3: step(1'b1, 2'd0, 24'h7FFFFF, 24'd0, 24'd0, 24'd0);
        default: step(1'b1, 2'd0, 24'd0, 24'd0, 24'd0, 24'd0);
      endcase
    end
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].v, tbl[k].st, tbl[k].dr, tbl[k].di, tbl[k].wr, tbl[k].wi);
      chk($sformatf("tbl%0d_valid", k), {23'd0, out_valid}, {23'd0, tbl[k].ev});
      if (tbl[k].ev) begin
        chk($sformatf("tbl%0d_r", k), dout_r, tbl[k].er);
        chk($sformatf("tbl%0d_i", k), dout_i, tbl[k].ei);
      end
    end
    // Four reserved cycles mid-frame, then finish the frame and read back a-b results.
    for (int k = 0; k < 4; k++) step(1'b1, 2'd3, 24'd77, 24'd77, 24'd0, 24'd0);
    for (int n = 5; n < 32; n++) step(1'b1, 2'd1, 24'd0, 24'd0, 24'd0, 24'd0);
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 2'd2, 24'd0, 24'd0, 24'd256, 24'd0);
      if (n == 3) chk("wrap_diff_zero", dout_r, 24'd0);
      if (n == 4) chk("after_rsv_diff", dout_i, 24'hFFFFFD);
    end

    // Random frames with random gaps and reserved cycles.
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 32; n++) step(1'b1, 2'd0, 24'($urandom), 24'($urandom), 24'd0, 24'd0);
      for (int p = 0; p < 3; p++) begin
        for (int n = 0; n < 32; n++) begin
          if ($urandom_range(0, 7) == 0)
            step($urandom_range(0, 1) == 1, 2'd3, 24'($urandom), 24'($urandom), 24'd0, 24'd0);
          step(1'b1, 2'd1, 24'($urandom), 24'($urandom), 24'd0, 24'd0);
        end
        for (int n = 0; n < 32; n++) begin
          if ($urandom_range(0, 7) == 0)
            step(1'b0, 2'd2, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
          step(1'b1, 2'd2, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
